sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the five-stage ARM pipeline's data memory port. It accepts one word read or write per request from the MEM stage and runs it as two 16-bit accesses on an external asynchronous SRAM. It drives `ready` back to the pipeline, and the top level derives the pipeline-wide freeze from `~ready` while an access is in flight.

## Interface
- `WAIT_CYCLES`, default 5: total busy cycles after the request cycle; must be ≥ 2.
- `BASE_ADDR`, default 32'd1024: byte address that maps to SRAM word 0.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `rd_en`  in  1  MEM-stage load request.
- `wr_en`  in  1  MEM-stage store request.
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data, registered.
- `ready`  out  1  high when no access is pending or the access completes this cycle.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_in`  in  16  SRAM data from the pad.
- `sram_dq_out`  out  16  SRAM data to the pad.
- `sram_dq_oe`  out  1  pad output enable.
- `sram_we_n`  out  1  write strobe, active-low.
- `sram_oe_n`  out  1  output enable, active-low.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  tied to 0.

## Operation
- **Address mapping:** `word = (address - BASE_ADDR) >> 2`, computed modulo 2^32.
  - Low half-word goes to `sram_addr = {word[16:0],1'b0}`.
  - High half-word goes to `{word[16:0],1'b1}`.
  - Upper bits are truncated, so out-of-range addresses wrap silently.
- **FSM states:** IDLE, LOW, HIGH, WAIT, DONE.
- **IDLE:**
  - If `wr_en` is high, latch `address` and `write_data`, mark the access as a write, go to LOW.
  - If only `rd_en` is high, latch `address`, mark the access as a read, go to LOW.
  - When `rd_en` and `wr_en` are high together, the access is a write.
- **LOW:** drive the low half-word address.
  - Write: `sram_dq_out = wdata[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - Read: `sram_oe_n = 0`; capture `sram_dq_in` into `read_data[15:0]` at the clock edge.
  - Go to HIGH.
- **HIGH:** same as LOW for the high half-word using `wdata[31:16]` / `read_data[31:16]`. Go to WAIT, or go straight to DONE when `WAIT_CYCLES == 2`.
- **WAIT:** all strobes inactive, counter increments. Leave for DONE when WAIT_CYCLES-2 WAIT cycles have elapsed.
- **DONE:** `ready = 1` for exactly one cycle; the next state is IDLE unconditionally.
- **`ready` equation:** `ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en)`. It is combinational from state and requests.
- **Dropped request:** the access runs to completion from the latched values even if `rd_en`/`wr_en` deassert mid-access.
- **`read_data`:** changes only on read captures in LOW/HIGH, and holds between reads, including across writes.
- **Strobes outside LOW/HIGH:** `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_dq_out = 0`.

## Timing
- **Reset:** `rst` high at an edge puts the block in IDLE after that edge, including mid-access.
  - Counter is 0 and `read_data = 0`.
  - `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_dq_out = 0`, `sram_addr = 0`.
  - An interrupted SRAM write is abandoned; no further strobe is issued.
- **Access timing, request seen in IDLE at cycle T:**
  - LOW at T+1, HIGH at T+2, WAIT from T+3 through T+WAIT_CYCLES, DONE at T+WAIT_CYCLES+1.
  - `ready` is 0 for WAIT_CYCLES+1 cycles (T..T+WAIT_CYCLES).
  - `ready` is 1 at T+WAIT_CYCLES+1, and `read_data` is valid in that cycle.
- **Write strobe:** `sram_we_n` is low for exactly 2 cycles (T+1, T+2). Address and data are stable throughout each low cycle.
- **Back-to-back:** a request present in the cycle after DONE starts a new access at that cycle. There is no idle gap beyond DONE.
- **Boundary cases:**
  - `address < BASE_ADDR` wraps through the modulo arithmetic; no error.
  - `address[1:0]` is ignored.

## Test plan
- **Reset:** hold `rst` 2 cycles → `ready = 1` (no request), `read_data = 0`, `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`.
- **Read:** SRAM model holds [0] = 16'hBEEF, [1] = 16'hDEAD. Pulse `rd_en` with `address = 1024` at T and hold it asserted → `ready = 0` for T..T+5, `ready = 1` at T+6, `read_data = 32'hDEADBEEF`. `sram_addr` is 0 at T+1 and 1 at T+2.
- **Write:** `wr_en` with `address = 1028`, `write_data = 32'h12345678` → SRAM [2] = 16'h5678 at T+1, [3] = 16'h1234 at T+2. `sram_we_n` is low only in T+1 and T+2; `read_data` is unchanged.
- **Conflicting and back-to-back requests:**
  - `rd_en` and `wr_en` both high → a write is performed.
  - A request kept high after DONE → the second access starts the next cycle and `ready` falls again.
  - Request dropped at T+2 → the access still completes with `ready = 1` at T+6.
- **Reset mid-write:** assert `rst` at T+1 of a write → IDLE after the edge, `sram_we_n = 1`, `sram_dq_oe = 0`. No strobe on SRAM [3] (the high half-word); SRAM [2] may already hold 16'h5678.
- **Parameterised timing:** `WAIT_CYCLES = 2` → `ready` low for 3 cycles, DONE at T+3. Read at `address = 1020` → `sram_addr = 18'h3FFFE` (wraps).

Source files
------------

// File: rtl/sram_controller_if.sv
// Pipeline-side data-memory port: one word request in, ready/read data back.
// The MEM stage is the master and the SRAM controller is the slave.
interface sram_controller_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output rd_en,
      output wr_en,
      output address,
      output write_data,
      input  read_data,
      input  ready
   );

   modport slave (
      input  rd_en,
      input  wr_en,
      input  address,
      input  write_data,
      output read_data,
      output ready
   );
endinterface

// File: rtl/sram_controller.sv
// Runs one 32-bit pipeline load/store as two 16-bit accesses on an async SRAM,
// then holds the pipeline with ~ready for a fixed number of settle cycles.
module sram_controller #(
   parameter int          WAIT_CYCLES = 5,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   bus,
   output logic [17:0]        sram_addr,
   input  logic [15:0]        sram_dq_in,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               sram_oe_n,
   output logic               sram_ce_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'((WAIT_CYCLES > 2) ? (WAIT_CYCLES - 3) : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_write;
   logic [16:0]   r_word;
   logic [15:0]   r_wdata_hi;
   logic [31:0]   r_read;
   logic [17:0]   r_addr;
   logic [15:0]   r_dq_out;
   logic          r_dq_oe;
   logic          r_we_n;
   logic          r_oe_n;

   logic [31:0]   w_diff;
   logic [16:0]   w_word;
   logic          w_req;
   logic          w_unused;

   // Byte offset from the SRAM window; high bits and byte lanes are discarded.
   assign w_diff   = bus.address - BASE_ADDR;
   assign w_word   = w_diff[18:2];
   assign w_req    = bus.rd_en | bus.wr_en;
   assign w_unused = ^{w_diff[31:19], w_diff[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_is_write <= 1'b0;
         r_word     <= '0;
         r_wdata_hi <= '0;
         r_read     <= '0;
         r_addr     <= '0;
         r_dq_out   <= '0;
         r_dq_oe    <= 1'b0;
         r_we_n     <= 1'b1;
         r_oe_n     <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  // Strobes are registered, so the LOW-cycle drive is set up here.
                  r_is_write <= bus.wr_en;
                  r_word     <= w_word;
                  r_wdata_hi <= bus.write_data[31:16];
                  r_addr     <= {w_word, 1'b0};
                  r_we_n     <= ~bus.wr_en;
                  r_oe_n     <= bus.wr_en;
                  r_dq_oe    <= bus.wr_en;
                  r_dq_out   <= bus.wr_en ? bus.write_data[15:0] : 16'h0000;
                  r_state    <= S_LOW;
               end
            end
            S_LOW: begin
               if (!r_is_write) begin
                  r_read[15:0] <= sram_dq_in;
               end
               r_addr   <= {r_word, 1'b1};
               r_dq_out <= r_is_write ? r_wdata_hi : 16'h0000;
               r_state  <= S_HIGH;
            end
            S_HIGH: begin
               if (!r_is_write) begin
                  r_read[31:16] <= sram_dq_in;
               end
               r_we_n   <= 1'b1;
               r_oe_n   <= 1'b1;
               r_dq_oe  <= 1'b0;
               r_dq_out <= 16'h0000;
               r_cnt    <= '0;
               r_state  <= (WAIT_CYCLES == 2) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == LAST_CNT) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Combinational so the pipeline freeze drops in the same cycle as the request.
   assign bus.ready     = (r_state == S_DONE) |
                          ((r_state == S_IDLE) & ~bus.rd_en & ~bus.wr_en);
   assign bus.read_data = r_read;

   assign sram_addr   = r_addr;
   assign sram_dq_out = r_dq_out;
   assign sram_dq_oe  = r_dq_oe;
   assign sram_we_n   = r_we_n;
   assign sram_oe_n   = r_oe_n;
   assign sram_ce_n   = 1'b0;
   assign sram_ub_n   = 1'b0;
   assign sram_lb_n   = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default timing instance plus a
// WAIT_CYCLES=2 instance, each with a behavioural 16-bit SRAM.
module tb_sram_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   sram_controller_if bus1();
   sram_controller_if bus2();

   logic [17:0] addr1, addr2;
   logic [15:0] dqi1, dqi2, dqo1, dqo2;
   logic        oe1, oe2, we1_n, we2_n, oe1_n, oe2_n;
   logic        ce1_n, ub1_n, lb1_n, ce2_n, ub2_n, lb2_n;

   logic [15:0] mem1 [0:262143];
   logic [15:0] mem2 [0:262143];

   logic        pl_en  = 1'b0;
   logic        pl_sel = 1'b0;
   logic [17:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   sram_controller #(.WAIT_CYCLES(5), .BASE_ADDR(32'd1024)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .sram_addr(addr1), .sram_dq_in(dqi1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
      .sram_we_n(we1_n), .sram_oe_n(oe1_n),
      .sram_ce_n(ce1_n), .sram_ub_n(ub1_n), .sram_lb_n(lb1_n)
   );

   sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .sram_addr(addr2), .sram_dq_in(dqi2), .sram_dq_out(dqo2), .sram_dq_oe(oe2),
      .sram_we_n(we2_n), .sram_oe_n(oe2_n),
      .sram_ce_n(ce2_n), .sram_ub_n(ub2_n), .sram_lb_n(lb2_n)
   );

   assign dqi1 = oe1_n ? 16'h0000 : mem1[addr1];
   assign dqi2 = oe2_n ? 16'h0000 : mem2[addr2];

   always @(posedge clk) begin
      if (pl_en && !pl_sel)   mem1[pl_addr] <= pl_data;
      else if (!we1_n)        mem1[addr1]   <= dqo1;
   end

   always @(posedge clk) begin
      if (pl_en && pl_sel)    mem2[pl_addr] <= pl_data;
      else if (!we2_n)        mem2[addr2]   <= dqo2;
   end

   logic        exp_b;
   logic [31:0] exp_rd;
   int          lows;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic sel, input logic [17:0] a, input logic [15:0] d);
      pl_sel = sel; pl_addr = a; pl_data = d; pl_en = 1'b1;
      next_cycle();
      pl_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      n_vec++;
      if (bus1.ready !== 1'b1 || bus2.ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready got %b%b exp 11", bus1.ready, bus2.ready);
      end
      n_vec++;
      if (bus1.read_data !== 32'h0 || bus2.read_data !== 32'h0) begin
         n_err++; $display("FAIL reset_rdata got %h/%h exp 0", bus1.read_data, bus2.read_data);
      end
      n_vec++;
      if ({we1_n, oe1_n, oe1, dqo1, addr1} !== {1'b1, 1'b1, 1'b0, 16'h0, 18'h0}) begin
         n_err++; $display("FAIL reset_strobes got we_n=%b oe_n=%b dq_oe=%b dq=%h addr=%h exp 1 1 0 0 0",
                           we1_n, oe1_n, oe1, dqo1, addr1);
      end
      $display("reset: ready=%b read_data=%h", bus1.ready, bus1.read_data);
      next_cycle();
   endtask

   task automatic test_read;
      bit seen;
      bus1.address = 32'd1024; bus1.rd_en = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         #1;
         exp_b = (k == 6);
         n_vec++;
         if (bus1.ready !== exp_b) begin
            n_err++; $display("FAIL read_ready k=%0d got %b exp %b", k, bus1.ready, exp_b);
         end
         if (k == 1) begin
            n_vec++;
            if (addr1 !== 18'd0 || oe1_n !== 1'b0) begin
               n_err++; $display("FAIL read_low k=1 got addr=%h oe_n=%b exp 0 0", addr1, oe1_n);
            end
         end
         if (k == 2) begin
            n_vec++;
            if (addr1 !== 18'd1 || oe1_n !== 1'b0) begin
               n_err++; $display("FAIL read_high k=2 got addr=%h oe_n=%b exp 1 0", addr1, oe1_n);
            end
         end
         if (k != 6) next_cycle();
      end
      exp_rd = 32'hDEADBEEF;
      n_vec++;
      if (bus1.read_data !== exp_rd) begin
         n_err++; $display("FAIL read_data got %h exp %h", bus1.read_data, exp_rd);
      end
      $display("read 1024: read_data=%h", bus1.read_data);
      // rd_en still high: the next access starts in the cycle after DONE
      next_cycle(); #1;
      n_vec++;
      if (bus1.ready !== 1'b0) begin
         n_err++; $display("FAIL b2b_ready got %b exp 0", bus1.ready);
      end
      next_cycle();
      bus1.rd_en = 1'b0;
      #1;
      n_vec++;
      if (oe1_n !== 1'b0 || addr1 !== 18'd0) begin
         n_err++; $display("FAIL b2b_low got oe_n=%b addr=%h exp 0 0", oe1_n, addr1);
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         next_cycle(); #1;
         if (bus1.ready === 1'b1) begin seen = 1'b1; break; end
      end
      n_vec++;
      if (!seen) begin
         n_err++; $display("FAIL b2b_timeout got no ready exp ready within 20 cycles");
      end
      $display("back-to-back read: read_data=%h", bus1.read_data);
      next_cycle();
   endtask

   task automatic test_write;
      preload(1'b0, 18'd2, 16'h0000);
      preload(1'b0, 18'd3, 16'h0000);
      bus1.address = 32'd1028; bus1.write_data = 32'h12345678; bus1.wr_en = 1'b1;
      lows = 0;
      for (int k = 0; k <= 7; k++) begin
         if (k == 1) bus1.wr_en = 1'b0;
         #1;
         if (we1_n === 1'b0) lows++;
         if (k == 1) begin
            n_vec++;
            if ({we1_n, oe1, addr1, dqo1} !== {1'b0, 1'b1, 18'd2, 16'h5678}) begin
               n_err++; $display("FAIL write_low got we_n=%b dq_oe=%b addr=%h dq=%h exp 0 1 2 5678",
                                 we1_n, oe1, addr1, dqo1);
            end
         end
         if (k == 2) begin
            n_vec++;
            if ({we1_n, oe1, addr1, dqo1} !== {1'b0, 1'b1, 18'd3, 16'h1234}) begin
               n_err++; $display("FAIL write_high got we_n=%b dq_oe=%b addr=%h dq=%h exp 0 1 3 1234",
                                 we1_n, oe1, addr1, dqo1);
            end
         end
         if (k == 6) begin
            n_vec++;
            if (bus1.ready !== 1'b1) begin
               n_err++; $display("FAIL write_done got %b exp 1", bus1.ready);
            end
         end
         next_cycle();
      end
      n_vec++;
      if (lows != 2) begin
         n_err++; $display("FAIL write_we_cycles got %0d exp 2", lows);
      end
      n_vec++;
      if (mem1[2] !== 16'h5678 || mem1[3] !== 16'h1234) begin
         n_err++; $display("FAIL write_mem got %h %h exp 5678 1234", mem1[2], mem1[3]);
      end
      n_vec++;
      if (bus1.read_data !== exp_rd) begin
         n_err++; $display("FAIL write_rdata_hold got %h exp %h", bus1.read_data, exp_rd);
      end
      $display("write 1028 <= 12345678: mem[2]=%h mem[3]=%h", mem1[2], mem1[3]);
   endtask

   task automatic test_dropped;
      preload(1'b0, 18'd0, 16'h1111);
      preload(1'b0, 18'd1, 16'h2222);
      bus1.address = 32'd1024; bus1.rd_en = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         if (k == 2) bus1.rd_en = 1'b0;
         #1;
         exp_b = (k == 6);
         n_vec++;
         if (bus1.ready !== exp_b) begin
            n_err++; $display("FAIL drop_ready k=%0d got %b exp %b", k, bus1.ready, exp_b);
         end
         if (k != 6) next_cycle();
      end
      exp_rd = 32'h22221111;
      n_vec++;
      if (bus1.read_data !== exp_rd) begin
         n_err++; $display("FAIL drop_rdata got %h exp %h", bus1.read_data, exp_rd);
      end
      $display("dropped read 1024: read_data=%h", bus1.read_data);
      next_cycle();
   endtask

   task automatic test_conflict;
      preload(1'b0, 18'd4, 16'h0000);
      preload(1'b0, 18'd5, 16'h0000);
      bus1.address = 32'd1032; bus1.write_data = 32'hAAAA5555;
      bus1.rd_en = 1'b1; bus1.wr_en = 1'b1;
      next_cycle();
      bus1.rd_en = 1'b0; bus1.wr_en = 1'b0;
      #1;
      n_vec++;
      if (we1_n !== 1'b0 || oe1_n !== 1'b1) begin
         n_err++; $display("FAIL conflict_kind got we_n=%b oe_n=%b exp 0 1", we1_n, oe1_n);
      end
      for (int k = 1; k <= 6; k++) next_cycle();
      n_vec++;
      if (mem1[4] !== 16'h5555 || mem1[5] !== 16'hAAAA || bus1.read_data !== exp_rd) begin
         n_err++; $display("FAIL conflict_result got %h %h rd=%h exp 5555 aaaa rd=%h",
                           mem1[4], mem1[5], bus1.read_data, exp_rd);
      end
      $display("rd+wr 1032 <= aaaa5555: mem[4]=%h mem[5]=%h", mem1[4], mem1[5]);
   endtask

   task automatic test_reset_mid_write;
      preload(1'b0, 18'd2, 16'h0000);
      preload(1'b0, 18'd3, 16'h0000);
      bus1.address = 32'd1028; bus1.write_data = 32'hCAFEF00D; bus1.wr_en = 1'b1;
      next_cycle();
      bus1.wr_en = 1'b0;
      rst = 1'b1;
      #1;
      n_vec++;
      if (we1_n !== 1'b0) begin
         n_err++; $display("FAIL rstw_started got we_n=%b exp 0", we1_n);
      end
      next_cycle();
      rst = 1'b0;
      #1;
      n_vec++;
      if ({we1_n, oe1, bus1.ready, bus1.read_data} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
         n_err++; $display("FAIL rstw_idle got we_n=%b dq_oe=%b ready=%b rd=%h exp 1 0 1 0",
                           we1_n, oe1, bus1.ready, bus1.read_data);
      end
      lows = 0;
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         if (we1_n === 1'b0) lows++;
      end
      n_vec++;
      if (lows != 0 || mem1[3] !== 16'h0000) begin
         n_err++; $display("FAIL rstw_no_strobe got lows=%0d mem[3]=%h exp 0 0000", lows, mem1[3]);
      end
      exp_rd = 32'h0;
      $display("reset mid-write: mem[2]=%h mem[3]=%h", mem1[2], mem1[3]);
   endtask

   task automatic test_wait2;
      preload(1'b1, 18'h3FFFE, 16'h1357);
      preload(1'b1, 18'h3FFFF, 16'h2468);
      bus2.address = 32'd1020; bus2.rd_en = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         if (k == 1) bus2.rd_en = 1'b0;
         #1;
         exp_b = (k == 3);
         n_vec++;
         if (bus2.ready !== exp_b) begin
            n_err++; $display("FAIL w2_ready k=%0d got %b exp %b", k, bus2.ready, exp_b);
         end
         if (k == 1) begin
            n_vec++;
            if (addr2 !== 18'h3FFFE) begin
               n_err++; $display("FAIL w2_addr_low got %h exp 3fffe", addr2);
            end
         end
         if (k == 2) begin
            n_vec++;
            if (addr2 !== 18'h3FFFF) begin
               n_err++; $display("FAIL w2_addr_high got %h exp 3ffff", addr2);
            end
         end
         if (k != 3) next_cycle();
      end
      n_vec++;
      if (bus2.read_data !== 32'h24681357) begin
         n_err++; $display("FAIL w2_rdata got %h exp 24681357", bus2.read_data);
      end
      $display("wait2 read 1020: read_data=%h", bus2.read_data);
      next_cycle();
   endtask

   initial begin
      bus1.rd_en = 1'b0; bus1.wr_en = 1'b0; bus1.address = '0; bus1.write_data = '0;
      bus2.rd_en = 1'b0; bus2.wr_en = 1'b0; bus2.address = '0; bus2.write_data = '0;
      #1;
      test_reset();
      preload(1'b0, 18'd0, 16'hBEEF);
      preload(1'b0, 18'd1, 16'hDEAD);
      test_read();
      test_write();
      test_dropped();
      test_conflict();
      test_reset_mid_write();
      test_wait2();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
